// File: rtl/change_dispense_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_pkg : shared states, hopper select codes and default coin values  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package change_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACCUM    = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERR      = 3'd5
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_HI   = 2'b01;
   localparam logic [1:0] SEL_LO   = 2'b10;

   localparam int CREDIT_W_DEF    = 8;
   localparam int PRICE_DEF       = 30;
   localparam int COIN_HI_DEF     = 10;
   localparam int COIN_LO_DEF     = 2;
   localparam int ACK_TIMEOUT_DEF = 15;

endpackage
`default_nettype wire

// File: rtl/change_dispense_ctrl_hopper_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hopper_watchdog : counts un-acknowledged hopper request cycles           |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module hopper_watchdog
   import change_pkg::*;
#(
   parameter int TIMEOUT = ACK_TIMEOUT_DEF
)(
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic clear,
   output logic expire
);

   localparam int C_CNT_W = $clog2(TIMEOUT + 1);

   logic [C_CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!start || clear) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + C_CNT_W'(1);
      end
   end

   // Fires on the TIMEOUT-th consecutive cycle the request went unanswered.
   assign expire = start && !clear && (r_cnt == C_CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispense_ctrl : credit accumulator and change-dispense sequencer  |
// | Option macro CHANGE_WATCHDOG_EN adds a hopper-ack watchdog (ERR state).  |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module change_dispense_ctrl
   import change_pkg::*;
#(
   parameter int CREDIT_W    = CREDIT_W_DEF,
   parameter int PRICE       = PRICE_DEF,
   parameter int COIN_HI     = COIN_HI_DEF,
   parameter int COIN_LO     = COIN_LO_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [4:0]          coin_value,
   input  logic                pay,
   input  logic                hopper_rdy,
   output logic                disp_valid,
   output logic [1:0]          disp_sel,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                done,
   output logic                short_pay,
   output logic                coin_rej,
   output logic                error
);

   localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] C_COIN_HI = CREDIT_W'(COIN_HI);
   localparam logic [CREDIT_W-1:0] C_COIN_LO = CREDIT_W'(COIN_LO);

   state_t              r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt, w_credit_acc, w_coin_amt;
   logic [CREDIT_W:0]   w_sum;
   logic [1:0]          r_sel, w_sel_nxt;
   logic                r_coin_rej, r_short_pay, w_short_nxt;
   logic                w_busy, w_handshake, w_expire;

   assign w_sum = {1'b0, r_credit} + {{(CREDIT_W-4){1'b0}}, coin_value};

   // Saturating credit as it would stand after this cycle's coin.
   always_comb begin
      w_credit_acc = r_credit;
      if (coin_valid) begin
         w_credit_acc = w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];
      end
   end

   assign w_coin_amt  = (r_sel == SEL_HI) ? C_COIN_HI : C_COIN_LO;
   assign w_busy      = (r_state == ST_DISPENSE) || (r_state == ST_WAIT_ACK) ||
                        (r_state == ST_DONE);
   assign w_handshake = (r_state == ST_WAIT_ACK) && hopper_rdy;

`ifdef CHANGE_WATCHDOG_EN
   hopper_watchdog #(
      .TIMEOUT (ACK_TIMEOUT)
   ) u_hopper_watchdog (
      .clock  (clock),
      .reset  (reset),
      .start  (r_state == ST_WAIT_ACK),
      .clear  (hopper_rdy),
      .expire (w_expire)
   );
   assign error = (r_state == ST_ERR);
`else
   assign w_expire = 1'b0;
   assign error    = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_sel_nxt    = r_sel;
      w_short_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_credit_nxt = w_credit_acc;
            if (coin_valid && (coin_value != 5'd0)) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            w_credit_nxt = w_credit_acc;
            if (pay) begin
               if (w_credit_acc >= C_PRICE) begin
                  w_credit_nxt = w_credit_acc - C_PRICE;
                  w_state_nxt  = ST_DISPENSE;
               end else begin
                  w_short_nxt = 1'b1;
               end
            end
         end
         ST_DISPENSE: begin
            if (r_credit >= C_COIN_HI) begin
               w_sel_nxt   = SEL_HI;
               w_state_nxt = ST_WAIT_ACK;
            end else if (r_credit >= C_COIN_LO) begin
               w_sel_nxt   = SEL_LO;
               w_state_nxt = ST_WAIT_ACK;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_WAIT_ACK: begin
            if (w_handshake) begin
               w_credit_nxt = r_credit - w_coin_amt;
               w_state_nxt  = ST_DISPENSE;
            end else if (w_expire) begin
               w_state_nxt = ST_ERR;
            end
         end
         ST_DONE: begin
            w_state_nxt = (r_credit == '0) ? ST_IDLE : ST_ACCUM;
         end
         ST_ERR: begin
            w_state_nxt = ST_ERR;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_credit    <= '0;
         r_sel       <= SEL_NONE;
         r_coin_rej  <= 1'b0;
         r_short_pay <= 1'b0;
      end else begin
         r_credit    <= w_credit_nxt;
         r_sel       <= w_sel_nxt;
         r_coin_rej  <= w_busy && coin_valid;
         r_short_pay <= w_short_nxt;
      end
   end

   // The dispense decision guarantees credit covers the coin being paid out.
   always_ff @(posedge clock) begin
      assert (ACK_TIMEOUT > 0);
      if (!reset && w_handshake) begin
         assert (r_credit >= w_coin_amt);
      end
   end

   assign disp_valid = (r_state == ST_WAIT_ACK);
   assign disp_sel   = disp_valid ? r_sel : SEL_NONE;
   assign credit     = r_credit;
   assign busy       = w_busy;
   assign done       = (r_state == ST_DONE);
   assign short_pay  = r_short_pay;
   assign coin_rej   = r_coin_rej;

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_change_dispense_ctrl : self-checking bench with a coin-queue model    |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_change_dispense_ctrl;

   logic       clock      = 1'b0;
   logic       reset      = 1'b0;
   logic       coin_valid = 1'b0;
   logic [4:0] coin_value = 5'd0;
   logic       pay        = 1'b0;
   logic       hopper_rdy = 1'b0;
   logic       disp_valid;
   logic [1:0] disp_sel;
   logic [7:0] credit;
   logic       busy, done, short_pay, coin_rej, error;

`ifdef CHANGE_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   always #5 clock = ~clock;

   change_dispense_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .coin_valid (coin_valid),
      .coin_value (coin_value),
      .pay        (pay),
      .hopper_rdy (hopper_rdy),
      .disp_valid (disp_valid),
      .disp_sel   (disp_sel),
      .credit     (credit),
      .busy       (busy),
      .done       (done),
      .short_pay  (short_pay),
      .coin_rej   (coin_rej),
      .error      (error)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: a sale is a queue of change coins paid out with one
   // decision cycle before each coin and one before the done pulse.
   int m_credit;
   bit m_accum, m_active, m_err, m_rej, m_short;
   int m_phase;   // 0 = deciding, 1 = presenting q[0], 2 = done pulse
   int m_wait;
   int q[$];

   task automatic model_reset();
      m_credit = 0; m_accum = 0; m_active = 0; m_err = 0;
      m_rej = 0; m_short = 0; m_phase = 0; m_wait = 0;
      q.delete();
   endtask

   task automatic model_step();
      bit was_accum;
      int sum, ch;
      was_accum = m_accum;
      m_rej     = coin_valid && m_active;
      m_short   = 0;
      if (m_err) begin
      end else if (!m_active) begin
         if (coin_valid) begin
            sum = m_credit + int'(coin_value);
            m_credit = (sum > 255) ? 255 : sum;
            if (coin_value != 0) m_accum = 1;
         end
         if (was_accum && pay) begin
            if (m_credit >= 30) begin
               ch = m_credit - 30;
               m_credit = ch;
               q.delete();
               while (ch >= 10) begin q.push_back(10); ch -= 10; end
               while (ch >= 2)  begin q.push_back(2);  ch -= 2;  end
               m_active = 1;
               m_phase  = 0;
            end else begin
               m_short = 1;
            end
         end
      end else begin
         case (m_phase)
            0: begin
               if (q.size() > 0) begin m_phase = 1; m_wait = 0; end
               else m_phase = 2;
            end
            1: begin
               if (hopper_rdy) begin
                  m_credit -= q.pop_front();
                  m_phase = 0;
               end else begin
                  m_wait++;
                  if (WD && m_wait >= 15) begin m_err = 1; m_active = 0; end
               end
            end
            default: begin
               m_active = 0;
               m_accum  = (m_credit != 0);
            end
         endcase
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // Event counters observed at the clock edge that consumes them.
   int n_hi = 0, n_lo = 0, n_done = 0, n_rej = 0, n_short = 0, n_dv = 0;
   always @(posedge clock) begin
      if (!reset) begin
         if (disp_valid && hopper_rdy) begin
            if (disp_sel == 2'b01) n_hi++;
            else if (disp_sel == 2'b10) n_lo++;
         end
         if (done)       n_done++;
         if (coin_rej)   n_rej++;
         if (short_pay)  n_short++;
         if (disp_valid) n_dv++;
      end
   end

   always @(negedge clock) begin : p_cmp
      int e_dv, e_sel;
      if (!reset) begin
         e_dv  = (m_active && m_phase == 1) ? 1 : 0;
         e_sel = (e_dv == 1 && q.size() > 0) ? ((q[0] == 10) ? 1 : 2) : 0;
         chk("credit",     int'(credit),     m_credit);
         chk("disp_valid", int'(disp_valid), e_dv);
         chk("disp_sel",   int'(disp_sel),   e_sel);
         chk("busy",       int'(busy),       int'(m_active));
         chk("done",       int'(done),       (m_active && m_phase == 2) ? 1 : 0);
         chk("short_pay",  int'(short_pay),  int'(m_short));
         chk("coin_rej",   int'(coin_rej),   int'(m_rej));
         chk("error",      int'(error),      int'(m_err));
      end
   end

   task automatic do_reset();
      reset = 1'b1; coin_valid = 1'b0; coin_value = 5'd0; pay = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic send_coin(input int v);
      coin_valid = 1'b1; coin_value = 5'(v);
      @(negedge clock);
      coin_valid = 1'b0; coin_value = 5'd0;
      @(negedge clock);
   endtask

   task automatic do_pay();
      pay = 1'b1;
      @(negedge clock);
      pay = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int start, k;
      start = n_done; k = 0;
      while (n_done == start && k < budget) begin @(negedge clock); k++; end
      chk("done_within_budget", int'(n_done != start), 1);
   endtask

   task automatic wait_dv(input int budget);
      int k;
      k = 0;
      while (!disp_valid && k < budget) begin @(negedge clock); k++; end
      chk("disp_valid_within_budget", int'(disp_valid), 1);
   endtask

   initial begin : p_timeout
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : p_main
      int b_hi, b_lo, b_rej, b_short, b_dv;

      do_reset();
      @(negedge clock);
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_dv",     int'(disp_valid), 0);
      chk("rst_error",  int'(error), 0);

      // T1: 40 credit -> one large coin, back to IDLE
      hopper_rdy = 1'b1;
      send_coin(10); send_coin(10); send_coin(20);
      b_hi = n_hi; b_lo = n_lo;
      do_pay();
      wait_done(40);
      chk("t1_hi_coins", n_hi - b_hi, 1);
      chk("t1_lo_coins", n_lo - b_lo, 0);
      chk("t1_credit",   int'(credit), 0);

      // T2: change 7 -> three small coins, residual 1 kept in ACCUM
      do_reset();
      send_coin(10); send_coin(20); send_coin(5); send_coin(2);
      b_hi = n_hi; b_lo = n_lo;
      do_pay();
      wait_done(40);
      chk("t2_lo_coins", n_lo - b_lo, 3);
      chk("t2_hi_coins", n_hi - b_hi, 0);
      chk("t2_credit",   int'(credit), 1);
      b_short = n_short;
      do_pay();
      @(negedge clock);
      chk("t2_accum_short", n_short - b_short, 1);

      // T3: insufficient credit
      do_reset();
      send_coin(20);
      b_short = n_short; b_dv = n_dv;
      do_pay();
      repeat (2) @(negedge clock);
      chk("t3_short", n_short - b_short, 1);
      chk("t3_no_dv", n_dv - b_dv, 0);
      chk("t3_credit", int'(credit), 20);

      // T4: hopper stalls 4 cycles, coin rejected mid-wait
      do_reset();
      hopper_rdy = 1'b0;
      send_coin(20); send_coin(20);
      do_pay();
      wait_dv(10);
      b_rej = n_rej; b_hi = n_hi;
      for (int i = 0; i < 4; i++) begin
         chk("t4_dv",     int'(disp_valid), 1);
         chk("t4_sel",    int'(disp_sel), 1);
         chk("t4_credit", int'(credit), 10);
         coin_valid = (i == 1);
         coin_value = (i == 1) ? 5'd5 : 5'd0;
         @(negedge clock);
      end
      coin_valid = 1'b0; coin_value = 5'd0;
      chk("t4_rej",        n_rej - b_rej, 1);
      chk("t4_credit_hold", int'(credit), 10);
      hopper_rdy = 1'b1;
      wait_done(20);
      chk("t4_one_coin",  n_hi - b_hi, 1);
      chk("t4_credit_end", int'(credit), 0);

      // T5: asynchronous reset during WAIT_ACK
      do_reset();
      hopper_rdy = 1'b0;
      send_coin(20); send_coin(20);
      do_pay();
      wait_dv(10);
      #2 reset = 1'b1;
      #1;
      chk("t5_dv",     int'(disp_valid), 0);
      chk("t5_sel",    int'(disp_sel), 0);
      chk("t5_credit", int'(credit), 0);
      chk("t5_busy",   int'(busy), 0);
      chk("t5_done",   int'(done), 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("t5_idle_busy",   int'(busy), 0);
      chk("t5_idle_credit", int'(credit), 0);

      // Saturation: 9 x 31 clamps at 255, change 225 = 22 large + 2 small
      do_reset();
      hopper_rdy = 1'b1;
      repeat (9) send_coin(31);
      chk("sat_credit", int'(credit), 255);
      b_hi = n_hi; b_lo = n_lo;
      do_pay();
      wait_done(200);
      chk("sat_hi", n_hi - b_hi, 22);
      chk("sat_lo", n_lo - b_lo, 2);
      chk("sat_residual", int'(credit), 1);

`ifdef CHANGE_WATCHDOG_EN
      // T6: hopper never answers
      do_reset();
      hopper_rdy = 1'b0;
      send_coin(20); send_coin(20);
      do_pay();
      repeat (20) @(negedge clock);
      chk("t6_error", int'(error), 1);
      chk("t6_dv",    int'(disp_valid), 0);
      send_coin(10);
      chk("t6_credit_frozen", int'(credit), 10);
      repeat (5) @(negedge clock);
      chk("t6_sticky", int'(error), 1);
      do_reset();
      @(negedge clock);
      chk("t6_cleared", int'(error), 0);
`endif

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         coin_valid = ($urandom_range(0, 99) < 30);
         coin_value = 5'($urandom_range(0, 31));
         pay        = ($urandom_range(0, 99) < 15);
         hopper_rdy = ($urandom_range(0, 99) < 70);
         @(negedge clock);
      end
      coin_valid = 1'b0; pay = 1'b0; hopper_rdy = 1'b1;
      repeat (100) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
